// File: rtl/wvb_storage_ring_if.sv
// Waveform-buffer bus: sample writer, random-access sample reader, header pop and status.
interface wvb_storage_ring_if #(
  parameter int unsigned P_DATA_WIDTH         = 22,
  parameter int unsigned P_ADR_WIDTH          = 12,
  parameter int unsigned P_HDR_WIDTH          = 80,
  parameter int unsigned P_N_WVF_IN_BUF_WIDTH = 16
);
  logic                                   wvb_wrreq;
  logic [P_DATA_WIDTH-1:0]                wvb_data_in;
  logic                                   eoe_in;
  logic [P_HDR_WIDTH-1:0]                 hdr_data_in;
  logic [P_ADR_WIDTH-1:0]                 wvb_rd_addr;
  logic [P_DATA_WIDTH-1:0]                wvb_data_out;
  logic                                   hdr_rdreq;
  logic [P_HDR_WIDTH+2*P_ADR_WIDTH-1:0]   hdr_data_out;
  logic                                   hdr_empty;
  logic                                   hdr_full;
  logic [P_N_WVF_IN_BUF_WIDTH-1:0]        n_wvf_in_buf;
  logic [P_ADR_WIDTH:0]                   wvb_used_words;
  logic                                   wvb_overflow;
  logic [15:0]                            dropped_cnt;
  logic                                   dropped_clr;

  modport master (
    output wvb_wrreq, wvb_data_in, eoe_in, hdr_data_in, wvb_rd_addr, hdr_rdreq, dropped_clr,
    input  wvb_data_out, hdr_data_out, hdr_empty, hdr_full, n_wvf_in_buf, wvb_used_words,
           wvb_overflow, dropped_cnt
  );

  modport slave (
    input  wvb_wrreq, wvb_data_in, eoe_in, hdr_data_in, wvb_rd_addr, hdr_rdreq, dropped_clr,
    output wvb_data_out, hdr_data_out, hdr_empty, hdr_full, n_wvf_in_buf, wvb_used_words,
           wvb_overflow, dropped_cnt
  );
endinterface

// File: rtl/wvb_storage_ring.sv
// Circular sample RAM plus header FIFO; commits whole waveforms or rolls them back.
// Optional dropped-waveform counter enabled by defining WVB_DROP_CNT_EN.
module wvb_storage_ring #(
  parameter int unsigned P_DATA_WIDTH         = 22,
  parameter int unsigned P_ADR_WIDTH          = 12,
  parameter int unsigned P_HDR_WIDTH          = 80,
  parameter int unsigned P_HDR_DEPTH_WIDTH    = 9,
  parameter int unsigned P_N_WVF_IN_BUF_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  wvb_storage_ring_if.slave bus
);
  localparam int unsigned RamDepth   = 2 ** P_ADR_WIDTH;
  localparam int unsigned HdrDepth   = 2 ** P_HDR_DEPTH_WIDTH;
  localparam int unsigned EntryWidth = P_HDR_WIDTH + 2 * P_ADR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_e;
  state_e state_q, state_d;

  logic [P_ADR_WIDTH:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wf_start_q, wf_start_d;
  logic [P_ADR_WIDTH:0]         used, cur_start;
  logic [P_HDR_DEPTH_WIDTH:0]   hdr_cnt_q, hdr_cnt_d;
  logic [P_HDR_DEPTH_WIDTH-1:0] hdr_wr_q, hdr_rd_q;
  logic                         ovf_q;
  logic [P_DATA_WIDTH-1:0]      rd_data_q;
  logic [P_DATA_WIDTH-1:0]      ram [RamDepth];
  logic [EntryWidth-1:0]        hdr_mem [HdrDepth];
  logic [EntryWidth-1:0]        head;
  logic [P_ADR_WIDTH-1:0]       head_stop;
  logic                         ring_full, hdr_full_int, hdr_empty_int;
  logic                         ram_we, hdr_push, hdr_pop, ovf_evt;

  assign used          = wr_ptr_q - rd_ptr_q;
  assign ring_full     = used[P_ADR_WIDTH];
  assign hdr_full_int  = hdr_cnt_q[P_HDR_DEPTH_WIDTH];
  assign hdr_empty_int = (hdr_cnt_q == '0);
  assign cur_start     = (state_q == StIdle) ? wr_ptr_q : wf_start_q;
  assign head          = hdr_mem[hdr_rd_q];
  assign head_stop     = head[P_HDR_WIDTH +: P_ADR_WIDTH];
  assign hdr_pop       = bus.hdr_rdreq && !hdr_empty_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StWrite: begin
        if (bus.wvb_wrreq) begin
          if (bus.eoe_in)     state_d = StIdle;
          else if (ring_full) state_d = StDrop;
          else                state_d = StWrite;
        end
      end
      StDrop:  if (bus.wvb_wrreq && bus.eoe_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    hdr_push   = 1'b0;
    ovf_evt    = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    wf_start_d = wf_start_q;
    if (state_q != StDrop && bus.wvb_wrreq) begin
      // A full header FIFO only matters on the committing sample.
      if (ring_full || (bus.eoe_in && hdr_full_int)) begin
        ovf_evt  = 1'b1;
        wr_ptr_d = cur_start;
      end else begin
        ram_we     = 1'b1;
        hdr_push   = bus.eoe_in;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        wf_start_d = cur_start;
      end
    end
  end

  // The head waveform always begins at rd_ptr, so its length follows from the stop address.
  assign rd_ptr_d = hdr_pop ? rd_ptr_q + {1'b0, head_stop - rd_ptr_q[P_ADR_WIDTH-1:0]} + 1'b1
                            : rd_ptr_q;

  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    case ({hdr_push, hdr_pop})
      2'b10:   hdr_cnt_d = hdr_cnt_q + 1'b1;
      2'b01:   hdr_cnt_d = hdr_cnt_q - 1'b1;
      default: hdr_cnt_d = hdr_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wf_start_q <= '0;
      hdr_cnt_q  <= '0;
      hdr_wr_q   <= '0;
      hdr_rd_q   <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wf_start_q <= wf_start_d;
      hdr_cnt_q  <= hdr_cnt_d;
      ovf_q      <= ovf_evt;
      rd_data_q  <= ram[bus.wvb_rd_addr];
      if (hdr_push) hdr_wr_q <= hdr_wr_q + 1'b1;
      if (hdr_pop)  hdr_rd_q <= hdr_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram[wr_ptr_q[P_ADR_WIDTH-1:0]] <= {bus.wvb_data_in[P_DATA_WIDTH-1:1], bus.eoe_in};
    end
    if (hdr_push && !rst) begin
      hdr_mem[hdr_wr_q] <= {cur_start[P_ADR_WIDTH-1:0], wr_ptr_q[P_ADR_WIDTH-1:0],
                            bus.hdr_data_in};
    end
  end

  assign bus.wvb_data_out   = rd_data_q;
  assign bus.hdr_data_out   = hdr_empty_int ? '0 : head;
  assign bus.hdr_empty      = hdr_empty_int;
  assign bus.hdr_full       = hdr_full_int;
  assign bus.n_wvf_in_buf   = P_N_WVF_IN_BUF_WIDTH'(hdr_cnt_q);
  assign bus.wvb_used_words = used;
  assign bus.wvb_overflow   = ovf_q;

  logic unused_lsb;
  assign unused_lsb = bus.wvb_data_in[0];

`ifdef WVB_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     drop_cnt_q <= '0;
    else if (bus.dropped_clr)                    drop_cnt_q <= '0;
    else if (ovf_evt && drop_cnt_q != 16'hFFFF)  drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign bus.dropped_cnt = drop_cnt_q;
`else
  logic unused_clr;
  assign unused_clr      = bus.dropped_clr;
  assign bus.dropped_cnt = '0;
`endif

endmodule

// File: tb/tb_wvb_storage_ring.sv
// Bench for wvb_storage_ring: directed scenarios plus random traffic against a queue-based model.
module tb_wvb_storage_ring;
  localparam int DataW    = 22;
  localparam int AdrW     = 4;
  localparam int HdrW     = 16;
  localparam int HdrDepW  = 2;
  localparam int NWvfW    = 16;
  localparam int RamDepth = 16;
  localparam int HdrDepth = 4;
  localparam int EntryW   = HdrW + 2 * AdrW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wvb_storage_ring_if #(
    .P_DATA_WIDTH(DataW), .P_ADR_WIDTH(AdrW), .P_HDR_WIDTH(HdrW), .P_N_WVF_IN_BUF_WIDTH(NWvfW)
  ) bus ();

  wvb_storage_ring #(
    .P_DATA_WIDTH(DataW), .P_ADR_WIDTH(AdrW), .P_HDR_WIDTH(HdrW),
    .P_HDR_DEPTH_WIDTH(HdrDepW), .P_N_WVF_IN_BUF_WIDTH(NWvfW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Model: committed waveforms as a queue, in-flight length, ring base address.
  typedef struct {
    logic [AdrW-1:0] start;
    logic [AdrW-1:0] stop;
    logic [HdrW-1:0] hdr;
    int              len;
  } wf_t;

  wf_t              mq[$];
  int               m_committed, m_cur_len, m_rd;
  bit               m_drop, m_ovf, m_rdata_ok;
  logic [DataW-1:0] m_ram[RamDepth];
  bit               m_ram_ok[RamDepth];
  logic [DataW-1:0] m_rdata;
  logic [15:0]      m_cnt;
  int               n_checks = 0;
  int               n_pass = 0;
  logic [15:0]      exp_cnt3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_committed = 0;
    m_cur_len   = 0;
    m_rd        = 0;
    m_drop      = 0;
    m_ovf       = 0;
    m_rdata     = '0;
    m_rdata_ok  = 1;
    m_cnt       = '0;
  endtask

  function automatic logic [EntryW-1:0] head_exp();
    if (mq.size() == 0) return '0;
    return {mq[0].start, mq[0].stop, mq[0].hdr};
  endfunction

  task automatic model_step();
    int  used, addr;
    bit  ovf, do_pop;
    wf_t w;
    if (rst) begin
      model_reset();
      return;
    end
    used       = m_committed + m_cur_len;
    m_rdata    = m_ram[bus.wvb_rd_addr];
    m_rdata_ok = m_ram_ok[bus.wvb_rd_addr];
    do_pop     = bus.hdr_rdreq && (mq.size() > 0);
    ovf        = 0;
    if (bus.wvb_wrreq) begin
      if (m_drop) begin
        if (bus.eoe_in) m_drop = 0;
      end else if (used == RamDepth || (bus.eoe_in && mq.size() == HdrDepth)) begin
        ovf       = 1;
        m_cur_len = 0;
        m_drop    = !bus.eoe_in;
      end else begin
        addr           = (m_rd + used) % RamDepth;
        m_ram[addr]    = {bus.wvb_data_in[DataW-1:1], bus.eoe_in};
        m_ram_ok[addr] = 1;
        m_cur_len++;
        if (bus.eoe_in) begin
          w.start = AdrW'((addr - m_cur_len + 1 + RamDepth) % RamDepth);
          w.stop  = AdrW'(addr);
          w.hdr   = bus.hdr_data_in;
          w.len   = m_cur_len;
          mq.push_back(w);
          m_committed += m_cur_len;
          m_cur_len = 0;
        end
      end
    end
    if (do_pop) begin
      m_rd        = (m_rd + mq[0].len) % RamDepth;
      m_committed -= mq[0].len;
      void'(mq.pop_front());
    end
    m_ovf = ovf;
`ifdef WVB_DROP_CNT_EN
    if (bus.dropped_clr)              m_cnt = '0;
    else if (ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic compare();
    chk("hdr_empty", bus.hdr_empty, mq.size() == 0);
    chk("hdr_full", bus.hdr_full, mq.size() == HdrDepth);
    chk("n_wvf_in_buf", bus.n_wvf_in_buf, mq.size());
    chk("wvb_used_words", bus.wvb_used_words, m_committed + m_cur_len);
    chk("hdr_data_out", bus.hdr_data_out, head_exp());
    chk("wvb_overflow", bus.wvb_overflow, m_ovf);
    chk("dropped_cnt", bus.dropped_cnt, m_cnt);
    if (m_rdata_ok) chk("wvb_data_out", bus.wvb_data_out, m_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    bus.wvb_wrreq   = 0;
    bus.wvb_data_in = '0;
    bus.eoe_in      = 0;
    bus.hdr_data_in = '0;
    bus.wvb_rd_addr = '0;
    bus.hdr_rdreq   = 0;
    bus.dropped_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic write_wf(input int len, input logic [DataW-1:0] base, input logic [HdrW-1:0] hdr);
    for (int i = 0; i < len; i++) begin
      bus.wvb_wrreq   = 1;
      bus.wvb_data_in = base + DataW'(i);
      bus.eoe_in      = (i == len - 1);
      bus.hdr_data_in = hdr;
      tick();
    end
    bus.wvb_wrreq = 0;
    bus.eoe_in    = 0;
  endtask

  task automatic pop();
    bus.hdr_rdreq = 1;
    tick();
    bus.hdr_rdreq = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
`ifdef WVB_DROP_CNT_EN
    exp_cnt3 = 16'd3;
`else
    exp_cnt3 = 16'd0;
`endif
    rst = 1;
    idle_inputs();
    model_reset();
    do_reset();
    chk("reset_empty", bus.hdr_empty, 1);
    chk("reset_used", bus.wvb_used_words, 0);
    chk("reset_hdr_out", bus.hdr_data_out, 0);

    // Two 5-word waveforms commit; a 7-word one overflows on its 7th word.
    write_wf(5, 22'h100000, 16'hA001);
    write_wf(5, 22'h200000, 16'hB002);
    chk("two_wf_n", bus.n_wvf_in_buf, 2);
    chk("two_wf_head", bus.hdr_data_out, {4'd0, 4'd4, 16'hA001});
    chk("two_wf_used", bus.wvb_used_words, 10);
    bus.wvb_rd_addr = 4'd4;
    tick();
    chk("rd_eoe_word", bus.wvb_data_out, 22'h100005);
    bus.wvb_rd_addr = 4'd1;
    tick();
    chk("rd_lsb_cleared", bus.wvb_data_out, 22'h100000);
    write_wf(7, 22'h300000, 16'hC003);
    chk("ovf_pulse", bus.wvb_overflow, 1);
    chk("ovf_rollback_used", bus.wvb_used_words, 10);
    chk("ovf_n", bus.n_wvf_in_buf, 2);
    tick();
    chk("ovf_pulse_end", bus.wvb_overflow, 0);

    // Pop, refill to the top of the ring, then wrap.
    pop();
    chk("pop_head", bus.hdr_data_out, {4'd5, 4'd9, 16'hB002});
    chk("pop_used", bus.wvb_used_words, 5);
    write_wf(6, 22'h000400, 16'hD004);
    write_wf(2, 22'h000500, 16'hE005);
    chk("wrap_n", bus.n_wvf_in_buf, 3);
    pop();
    chk("hdr_10_15", bus.hdr_data_out, {4'd10, 4'd15, 16'hD004});
    pop();
    chk("hdr_wrap_0_1", bus.hdr_data_out, {4'd0, 4'd1, 16'hE005});
    chk("wrap_used", bus.wvb_used_words, 2);

    // Header FIFO full: fifth single-word waveform is dropped.
    do_reset();
    for (int k = 0; k < 5; k++) write_wf(1, DataW'(k), HdrW'(16'h0100 + k));
    chk("hfull_ovf", bus.wvb_overflow, 1);
    chk("hfull_n", bus.n_wvf_in_buf, 4);
    chk("hfull_flag", bus.hdr_full, 1);
    chk("hfull_used", bus.wvb_used_words, 4);
    write_wf(1, 22'h5, 16'h0105);
    write_wf(1, 22'h6, 16'h0106);
    chk("drop_cnt_3", bus.dropped_cnt, exp_cnt3);
    bus.dropped_clr = 1;
    write_wf(1, 22'h7, 16'h0107);
    bus.dropped_clr = 0;
    chk("drop_cnt_clr", bus.dropped_cnt, 0);
    chk("drop_clr_ovf", bus.wvb_overflow, 1);

    // Simultaneous push and pop with one header stored.
    pop();
    pop();
    pop();
    chk("pp_pre_n", bus.n_wvf_in_buf, 1);
    bus.hdr_rdreq = 1;
    write_wf(1, 22'h9, 16'hF00F);
    bus.hdr_rdreq = 0;
    chk("pp_n", bus.n_wvf_in_buf, 1);
    chk("pp_head", bus.hdr_data_out, {4'd4, 4'd4, 16'hF00F});
    chk("pp_used", bus.wvb_used_words, 1);

    // Reset in the middle of a waveform.
    for (int i = 0; i < 3; i++) begin
      bus.wvb_wrreq   = 1;
      bus.eoe_in      = 0;
      bus.wvb_data_in = DataW'(i);
      tick();
    end
    bus.wvb_wrreq = 0;
    rst = 1;
    #1;
    chk("mid_rst_used", bus.wvb_used_words, 0);
    chk("mid_rst_n", bus.n_wvf_in_buf, 0);
    chk("mid_rst_empty", bus.hdr_empty, 1);
    chk("mid_rst_full", bus.hdr_full, 0);
    chk("mid_rst_hdr", bus.hdr_data_out, 0);
    chk("mid_rst_data", bus.wvb_data_out, 0);
    tick();
    rst = 0;
    write_wf(2, 22'h000700, 16'h1234);
    chk("post_rst_hdr", bus.hdr_data_out, {4'd0, 4'd1, 16'h1234});

    // Random traffic; heavier popping in the second half drains the ring.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.wvb_wrreq   = ($urandom_range(99) < 60);
      bus.eoe_in      = ($urandom_range(99) < 15);
      bus.wvb_data_in = DataW'($urandom);
      bus.hdr_data_in = HdrW'($urandom);
      bus.wvb_rd_addr = AdrW'($urandom);
      bus.hdr_rdreq   = ($urandom_range(99) < ((c < 2000) ? 12 : 45));
      bus.dropped_clr = ($urandom_range(99) < 2);
      rst             = ($urandom_range(999) < 2);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
